// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmit-side blocks.
//   UART_DBIT          default frame data width
//   ST_IDLE..ST_DONE   2-bit encoding of the transmit arbiter FSM
package uart_pkg;

  localparam int UART_DBIT = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundle between NREQ requesters, the transmit arbiter
// and the uart_tx serializer.
//   req/din            requester levels and their bytes (din slice i = requester i)
//   grant/done         one-hot completion handshakes back to requesters
//   owner/busy         current/last winner and transfer-in-progress flag
//   tx_start/tx_din    serializer kick and held frame data
//   tx_done_tick       serializer end-of-stop-bit pulse
// slave = arbiter side, master = client/serializer side.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int DBIT = UART_DBIT,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) ();

  logic [NREQ-1:0]      req;
  logic [NREQ*DBIT-1:0] din;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic [IDW-1:0]       owner;
  logic                 busy;
  logic                 tx_start;
  logic [DBIT-1:0]      tx_din;
  logic                 tx_done_tick;

  modport slave (
    input  req, din, tx_done_tick,
    output grant, done, owner, busy, tx_start, tx_din
  );

  modport master (
    output req, din, tx_done_tick,
    input  grant, done, owner, busy, tx_start, tx_din
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req  in   NREQ  request vector
//   ptr  in   IDW   highest-priority index (must be < NREQ)
//   any  out  1     at least one request present
//   idx  out  IDW   first requester at or above ptr, wrapping modulo NREQ
// The request vector is doubled and shifted down by ptr so a plain
// lowest-bit priority encode yields the offset from ptr; wrapping then needs
// only one conditional subtract, which also works for non-power-of-2 NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDW:0]      off;
  logic [IDW:0]      sum;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[NREQ-1:0];
    any = |req;
    off = '0;
    // Descending scan so the lowest set bit wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = (IDW+1)'(i);
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
    idx = sum[IDW-1:0];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer among NREQ requesters.
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   bus      slave side of uart_tx_arbiter_if (requests, grants, serializer link)
// IDLE picks a winner round-robin and latches its byte, LOAD pulses
// grant/tx_start, WAIT holds until tx_done_tick, DONE pulses done and moves
// the pointer past the winner. Every output is a flop or a decode of the
// state/owner flops, so req never reaches an output combinationally.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DBIT = UART_DBIT,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_tx_arbiter_if.slave bus
);

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  ptr_q,   ptr_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [DBIT-1:0] tx_din_q, tx_din_d;

  logic            pick_any;
  logic [IDW-1:0]  pick_idx;
  logic [NREQ-1:0] owner_oh;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    tx_din_d = tx_din_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d  = ST_LOAD;
          owner_d  = pick_idx;
          tx_din_d = bus.din[pick_idx*DBIT +: DBIT];
        end
      end
      ST_LOAD: state_d = ST_WAIT;
      // Ticks outside WAIT are spurious and fall through untouched.
      ST_WAIT: if (bus.tx_done_tick) state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      tx_din_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      tx_din_q <= tx_din_d;
    end
  end

  assign owner_oh     = NREQ'(1) << owner_q;
  assign bus.grant    = (state_q == ST_LOAD) ? owner_oh : '0;
  assign bus.done     = (state_q == ST_DONE) ? owner_oh : '0;
  assign bus.tx_start = (state_q == ST_LOAD);
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.owner    = owner_q;
  assign bus.tx_din   = tx_din_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench for uart_tx_arbiter.
// Expected (requester, byte) pairs are queued when a request is driven and
// popped when tx_start appears; a small serializer model drives the line
// from tx_din and returns tx_done_tick.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int DBIT    = 8;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int BIT_CYC = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.DBIT(DBIT), .NREQ(NREQ), .IDW(IDW)) bus ();

  uart_tx_arbiter #(.DBIT(DBIT), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int              idx;
    logic [DBIT-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  logic line;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [DBIT-1:0] d);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    sb.push_back(e);
    bus.din[idx*DBIT +: DBIT] = d;
  endtask

  // Wait (bounded) for tx_start, then check the grant against the scoreboard.
  task automatic wait_start(input int exp_lat, input bit drop);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.tx_start && n < 40);
    chk("tx_start_seen", 32'(bus.tx_start), 1);
    chk("sb_nonempty", 32'(sb.size() > 0), 1);
    if (!bus.tx_start || sb.size() == 0) return;
    cur = sb.pop_front();
    chk("start_latency", n, exp_lat);
    chk("grant", 32'(bus.grant), 1 << cur.idx);
    chk("owner", 32'(bus.owner), cur.idx);
    chk("tx_din", 32'(bus.tx_din), 32'(cur.data));
    chk("busy_load", 32'(bus.busy), 1);
    if (drop) bus.req[cur.idx] = 1'b0;
  endtask

  // Serialize the current frame, optionally pulse req[pulse_req] mid-frame,
  // then return tx_done_tick and check completion.
  task automatic finish_frame(input int pulse_req);
    logic [DBIT-1:0] rx;
    bit unstable, stray;
    rx = '0;
    unstable = 0;
    stray = 0;
    for (int b = 0; b < DBIT + 2; b++) begin
      for (int c = 0; c < BIT_CYC; c++) begin
        tick();
        line = (b == 0) ? 1'b0 : (b == DBIT + 1) ? 1'b1 : bus.tx_din[b-1];
        if (c == BIT_CYC / 2 && b >= 1 && b <= DBIT) rx[b-1] = line;
        if (bus.tx_din !== cur.data) unstable = 1;
        if (bus.grant !== '0 || bus.done !== '0 || bus.tx_start !== 1'b0 || bus.busy !== 1'b1)
          stray = 1;
        if (pulse_req >= 0 && b == 2 && c == 0) bus.req[pulse_req] = 1'b1;
        if (pulse_req >= 0 && b == 2 && c == 1) bus.req[pulse_req] = 1'b0;
      end
    end
    chk("line_byte", 32'(rx), 32'(cur.data));
    chk("tx_din_stable", 32'(unstable), 0);
    chk("quiet_in_wait", 32'(stray), 0);
    chk("state_wait", 32'(dut.state_q), 32'(ST_WAIT));
    bus.tx_done_tick = 1'b1;
    tick();
    bus.tx_done_tick = 1'b0;
    chk("done", 32'(bus.done), 1 << cur.idx);
    chk("busy_done", 32'(bus.busy), 1);
    chk("grant_in_done", 32'(bus.grant), 0);
    tick();
    chk("done_clear", 32'(bus.done), 0);
    chk("busy_idle", 32'(bus.busy), 0);
    chk("state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("ptr", 32'(dut.ptr_q), (cur.idx + 1) % NREQ);
  endtask

  initial begin
    bit seen;
    bus.req = '0;
    bus.din = '0;
    bus.tx_done_tick = 1'b0;
    line = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_tx_start", 32'(bus.tx_start), 0);
    chk("rst_tx_din", 32'(bus.tx_din), 0);
    chk("rst_owner", 32'(bus.owner), 0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("rst_ptr", 32'(dut.ptr_q), 0);
    reset_n = 1'b1;
    tick();

    // Full contention: all four held, served 0,1,2,3,0
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'h11);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start(1, 0);
      if (k == 4) bus.req = '0;
      finish_frame(-1);
    end

    // Single request A5 on requester 0
    push(0, 8'hA5);
    bus.req[0] = 1'b1;
    wait_start(1, 1);
    finish_frame(-1);

    // Spurious tick in IDLE, then in LOAD
    bus.tx_done_tick = 1'b1;
    tick();
    bus.tx_done_tick = 1'b0;
    chk("spur_idle_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("spur_idle_done", 32'(bus.done), 0);
    push(1, 8'h3C);
    bus.req[1] = 1'b1;
    wait_start(1, 1);
    bus.tx_done_tick = 1'b1;
    tick();
    bus.tx_done_tick = 1'b0;
    chk("spur_load_state", 32'(dut.state_q), 32'(ST_WAIT));
    chk("spur_load_done", 32'(bus.done), 0);
    finish_frame(-1);

    // Serve 2 so ptr sits at 3, then 1001 wraps 3 -> 0
    push(2, 8'h33);
    bus.req[2] = 1'b1;
    wait_start(1, 1);
    finish_frame(-1);
    push(3, 8'h44);
    push(0, 8'h11);
    bus.req = 4'b1001;
    wait_start(1, 1);
    finish_frame(-1);
    wait_start(1, 1);
    finish_frame(-1);

    // Withdraw: req[1] pulses one cycle while 0 is in WAIT
    push(0, 8'hC3);
    bus.req[0] = 1'b1;
    wait_start(1, 1);
    finish_frame(1);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.grant !== '0 || bus.busy !== 1'b0) seen = 1;
    end
    chk("withdraw_no_grant", 32'(seen), 0);

    // Reset mid-frame with requester 2 pending
    push(0, 8'h5A);
    bus.req[0] = 1'b1;
    wait_start(1, 1);
    for (int k = 0; k < 5 * BIT_CYC; k++) tick();
    bus.din[2*DBIT +: DBIT] = 8'h77;
    bus.req[2] = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(bus.grant), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_tx_start", 32'(bus.tx_start), 0);
    chk("mid_rst_tx_din", 32'(bus.tx_din), 0);
    chk("mid_rst_owner", 32'(bus.owner), 0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("mid_rst_ptr", 32'(dut.ptr_q), 0);
    tick();
    chk("mid_rst_no_done", 32'(bus.done), 0);
    reset_n = 1'b1;
    push(2, 8'h77);
    wait_start(1, 1);
    finish_frame(-1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
